// File: rtl/telemetry_scheduler.sv
// telemetry_scheduler: arbitrates per-channel level-change events and a periodic
// heartbeat onto a single byte-wide valid/ready link to the UART transmitter.
module telemetry_scheduler #(
    parameter int NUM_CHANNELS     = 8,
    parameter int HEARTBEAT_PERIOD = 50000,
    parameter int COUNT_WIDTH      = 4
) (
    input  logic                    clock_i,
    input  logic                    reset_n_i,
    input  logic                    enable_i,
    input  logic [NUM_CHANNELS-1:0] channel_state_i,
    input  logic [COUNT_WIDTH-1:0]  ones_count_i,
    input  logic                    tx_ready_i,
    output logic                    tx_valid_o,
    output logic [7:0]              tx_data_o,
    output logic [NUM_CHANNELS-1:0] pending_o,
    output logic                    overflow_o,
    output logic [2:0]              grant_o
);
    localparam int HW = HEARTBEAT_PERIOD > 1 ? $clog2(HEARTBEAT_PERIOD) : 1;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t state, state_nx;
    logic [NUM_CHANNELS-1:0] prev, change, sel_mask;
    logic [HW-1:0] hb_cnt;
    logic hb_pending, hb_wrap, go, sel_hb, sel_ch, found;
    logic [2:0] rr_idx, cand;
    logic [7:0] frame;

    assign change = channel_state_i ^ prev;
    assign hb_wrap = enable_i && hb_cnt == HW'(HEARTBEAT_PERIOD - 1);
    assign tx_valid_o = state == SEND;

    // first pending channel after the last grant, wrapping around
    always_comb begin
        found = 1'b0;
        rr_idx = '0;
        cand = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            cand = 3'((int'(grant_o) + k) % NUM_CHANNELS);
            if (!found && pending_o[cand]) begin
                found = 1'b1;
                rr_idx = cand;
            end
        end
    end

    always_comb begin
        go = state == IDLE && enable_i && (hb_pending || found);
        sel_hb = go && hb_pending;
        sel_ch = go && !hb_pending;
        sel_mask = sel_ch ? NUM_CHANNELS'(1) << rr_idx : '0;
        frame = sel_hb ? {4'b1000, 4'(ones_count_i)}
                       : {1'b0, rr_idx, 3'b000, channel_state_i[rr_idx]};
        state_nx = go ? SEND : state == SEND ? (tx_ready_i ? GAP : SEND) : IDLE;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // a change on the channel being granted re-queues it rather than overflowing
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            prev <= '0;
            pending_o <= '0;
            overflow_o <= 1'b0;
            hb_cnt <= '0;
            hb_pending <= 1'b0;
            tx_data_o <= '0;
            grant_o <= 3'(NUM_CHANNELS - 1);
        end else begin
            prev <= channel_state_i;
            pending_o <= (pending_o & ~sel_mask) | (enable_i ? change : '0);
            overflow_o <= overflow_o | (enable_i && |(change & pending_o & ~sel_mask));
            hb_cnt <= (!enable_i || hb_wrap) ? '0 : hb_cnt + 1'b1;
            hb_pending <= (hb_pending && !sel_hb) || (hb_wrap && !hb_pending);
            if (go)
                tx_data_o <= frame;
            if (sel_ch)
                grant_o <= rr_idx;
        end
    end
endmodule

// File: doc/telemetry_scheduler.md
Name: telemetry_scheduler

Overview:
- Shares the single UART transmitter between the eight PWM-analyzer channel outputs and a periodic heartbeat carrying the ones-counter value.
- Detects level changes on each channel, queues one pending event per channel, and arbitrates round-robin.
- Heartbeat has highest priority.
- Emits one byte per event to the UART transmitter over a valid/ready handshake; sits between the pwm_analyzer bank/ones_counter and uart_transmitter.

Parameters:
- NUM_CHANNELS, 8, number of channel inputs; index field fixed at 3 bits, so legal range 1..8.
- HEARTBEAT_PERIOD, 50000, clock cycles between heartbeat requests (50 ms at 1 MHz).
- COUNT_WIDTH, 4, width of ones_count_i.

Ports:
- clock_i  in  1  single clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  scheduler enable.
- channel_state_i  in  NUM_CHANNELS  pwm_analyzer outputs, synchronous to clock_i.
- ones_count_i  in  COUNT_WIDTH  current ones_counter value.
- tx_ready_i  in  1  UART transmitter can accept a byte.
- tx_valid_o  out  1  byte on tx_data_o is valid.
- tx_data_o  out  8  frame byte.
- pending_o  out  NUM_CHANNELS  per-channel pending flags.
- overflow_o  out  1  sticky: an event was lost.
- grant_o  out  3  index of the last granted channel.

Behaviour:
- Reset (reset_n_i low, asynchronous):
  - tx_valid_o=0, tx_data_o=0x00, pending_o=0, overflow_o=0, grant_o=NUM_CHANNELS-1.
  - prev-state register=0, heartbeat counter=0, hb_pending=0, FSM=IDLE.
- Change detect: change[i] = channel_state_i[i] ^ prev[i]. prev updates every cycle regardless of enable_i.
- A channel already high on the first cycle after reset therefore generates an event.
- Pending set: on change[i] with enable_i=1, pending[i] is set at the next edge.
- Overflow: change[i] while pending[i]=1 and channel i is not selected that cycle sets overflow_o. It stays set until reset.
- Change on the channel being selected in the same cycle: pending[i] stays 1 (new event queued); no overflow.
- Heartbeat counter:
  - Counts 0..HEARTBEAT_PERIOD-1 while enable_i=1; held at 0 while enable_i=0.
  - On wrap, sets hb_pending.
  - A wrap while hb_pending=1 is dropped silently (no overflow).
- FSM states:
  - IDLE: if enable_i=1 and (hb_pending or any pending), select a source:
    - hb_pending wins over channels.
    - Otherwise take the first pending channel searching from grant_o+1, wrapping modulo NUM_CHANNELS.
    - Clear the selected pending bit, latch tx_data_o, update grant_o (channel only), assert tx_valid_o, go to SEND.
  - SEND: hold tx_valid_o=1 and tx_data_o stable until tx_ready_i=1. On that edge the handshake completes: tx_valid_o=0, go to GAP.
  - GAP: exactly one cycle with tx_valid_o=0, then IDLE. This absorbs the UART's one-cycle lag in dropping ready.
- Frame format:
  - Channel frame: bit7=0, bits6:4=channel index, bits3:1=000, bit0=channel_state_i[index] sampled at selection.
  - Heartbeat frame: bit7=1, bits6:4=000, bits3:0=ones_count_i sampled at selection, zero-extended if COUNT_WIDTH<4.
- Latency:
  - Input change at edge t → pending at edge t+1 → tx_valid_o high after edge t+2 (FSM idle, no competing source).
  - Minimum spacing between successive selections is 3 cycles with tx_ready_i held high.
- enable_i=0:
  - A transfer in SEND completes normally.
  - No new selection; no new pending bits; existing pending bits are retained.
- Reset mid-transfer aborts immediately: tx_valid_o=0, all queued events discarded.

Test Plan:
- Reset release with channel_state_i=0x05, enable_i=1, tx_ready_i=1 → frames 0x01 then 0x21 (channels 0 and 2, state 1); grant_o=2; pending_o=0.
- Steady state, tx_ready_i=1: toggle channel 3 low→high at edge t → tx_valid_o high after edge t+2 with tx_data_o=0x31; handshake same cycle; GAP next cycle.
- tx_ready_i=0, pending_o=0xFF, grant_o=4: release ready → grant order 5,6,7,0,1,2,3,4; each frame is held stable while ready is low.
- HEARTBEAT_PERIOD=16, ones_count_i=6, channel 1 pending at the same time → heartbeat byte 0x86 sent first, then channel 1 frame.
- tx_ready_i=0, toggle channel 6 twice while pending → overflow_o=1 and stays 1 after tx_ready_i returns; only one channel-6 frame sent.
- Assert reset_n_i during SEND → tx_valid_o=0 asynchronously, pending_o=0, overflow_o=0, grant_o=7; next frame only after a new input change.
